smvm_tx: RTL



---
 rtl/smvm_tx_pkg.sv | 53 +++++
 rtl/smvm_tx_if.sv | 49 ++++
 rtl/smvm_tx_store.sv | 59 +++++
 rtl/smvm_tx.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/smvm_tx_pkg.sv
// ---------------------------------------------------------------------------
// smvm_pkg -- shared definitions for the SMVM transmitter and its receiver.
//
// Holds the default problem limits, the ALU lane count, the field widths of
// the 12-bit stream word, the transmitter state enumeration, and two small
// helpers that pack the 12-bit word driven onto val_out/ipv_out/col_out.
// ---------------------------------------------------------------------------
package smvm_pkg;

  localparam int K        = 4;
  localparam int MAX_COLS = 128;
  localparam int MAX_NNZ  = 256;

  // A stream word is {val[7:0], ipv, col[2:0]}.
  localparam int HDR_W = 12;
  localparam int VAL_W = 8;
  localparam int IPV_W = 1;
  localparam int COL_W = 3;

  // Store addressing and column index width.
  localparam int VEC_AW = 7;
  localparam int NZ_AW  = 8;
  localparam int IDX_W  = 7;

  // Launch configuration widths.
  localparam int ROWS_W = 8;
  localparam int COLS_W = 8;
  localparam int NNZ_W  = 9;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HROW,
    ST_HCOL,
    ST_VEC,
    ST_NZV,
    ST_NZI,
    ST_PADV,
    ST_PADI,
    ST_GAP
  } state_t;

  // Header words are plain zero-extended numbers laid across all 12 bits.
  function automatic logic [HDR_W-1:0] hdrWord(input logic [7:0] v);
    return HDR_W'(v);
  endfunction

  // Data words carry the byte on val, a flag on ipv and zero on col.
  function automatic logic [HDR_W-1:0] valWord(input logic [VAL_W-1:0] v,
                                               input logic flag);
    return {v, flag, COL_W'(0)};
  endfunction

endpackage

// File: rtl/smvm_tx_if.sv
// ---------------------------------------------------------------------------
// smvm_tx_if -- host-side bus of the SMVM transmitter.
//
// Groups the store write ports, the launch request with its configuration,
// and the outgoing SMVM stream plus status flags.
//   master : the host (drives writes/start, observes stream and status)
//   slave  : the transmitter
// ---------------------------------------------------------------------------
interface smvm_tx_if;
  import smvm_pkg::*;

  logic              vec_we;
  logic [VEC_AW-1:0] vec_addr;
  logic [VAL_W-1:0]  vec_wdata;

  logic              nz_we;
  logic [NZ_AW-1:0]  nz_addr;
  logic [VAL_W-1:0]  nz_val;
  logic [IDX_W-1:0]  nz_col;
  logic              nz_last;

  logic              start;
  logic [ROWS_W-1:0] cfg_rows;
  logic [COLS_W-1:0] cfg_cols;
  logic [NNZ_W-1:0]  cfg_nnz;

  logic              out_valid;
  logic [VAL_W-1:0]  val_out;
  logic              ipv_out;
  logic [COL_W-1:0]  col_out;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output vec_we, vec_addr, vec_wdata,
    output nz_we, nz_addr, nz_val, nz_col, nz_last,
    output start, cfg_rows, cfg_cols, cfg_nnz,
    input  out_valid, val_out, ipv_out, col_out, busy, done, err
  );

  modport slave (
    input  vec_we, vec_addr, vec_wdata,
    input  nz_we, nz_addr, nz_val, nz_col, nz_last,
    input  start, cfg_rows, cfg_cols, cfg_nnz,
    output out_valid, val_out, ipv_out, col_out, busy, done, err
  );

endinterface

// File: rtl/smvm_tx_store.sv
// ---------------------------------------------------------------------------
// smvm_tx_store -- vector and nonzero register arrays of the transmitter.
//
// Synchronous write, combinational read, no reset (contents survive rst).
//   clk                       : clock
//   vecWe_i/vecWaddr_i/...    : vector byte write
//   vecRaddr_i -> vecRdata_o  : vector byte read
//   nzWe_i/nzWaddr_i/...      : nonzero {value, column, row-end} write
//   nzRaddr_i -> nzR*_o       : nonzero read
// ---------------------------------------------------------------------------
module smvm_tx_store #(
  parameter int MAX_COLS = smvm_pkg::MAX_COLS,
  parameter int MAX_NNZ  = smvm_pkg::MAX_NNZ
) (
  input  logic                        clk,
  input  logic                        vecWe_i,
  input  logic [smvm_pkg::VEC_AW-1:0] vecWaddr_i,
  input  logic [smvm_pkg::VAL_W-1:0]  vecWdata_i,
  input  logic [smvm_pkg::VEC_AW-1:0] vecRaddr_i,
  output logic [smvm_pkg::VAL_W-1:0]  vecRdata_o,
  input  logic                        nzWe_i,
  input  logic [smvm_pkg::NZ_AW-1:0]  nzWaddr_i,
  input  logic [smvm_pkg::VAL_W-1:0]  nzWval_i,
  input  logic [smvm_pkg::IDX_W-1:0]  nzWcol_i,
  input  logic                        nzWlast_i,
  input  logic [smvm_pkg::NZ_AW-1:0]  nzRaddr_i,
  output logic [smvm_pkg::VAL_W-1:0]  nzRval_o,
  output logic [smvm_pkg::IDX_W-1:0]  nzRcol_o,
  output logic                        nzRlast_o
);
  import smvm_pkg::*;

  logic [VAL_W-1:0] vecMem_q  [MAX_COLS];
  logic [VAL_W-1:0] nzVal_q   [MAX_NNZ];
  logic [IDX_W-1:0] nzCol_q   [MAX_NNZ];
  logic             nzLast_q  [MAX_NNZ];

  // Vector store write; addresses beyond the configured depth are dropped.
  always_ff @(posedge clk) begin
    if (vecWe_i && (int'(vecWaddr_i) < MAX_COLS)) begin
      vecMem_q[vecWaddr_i] <= vecWdata_i;
    end
  end

  // Nonzero store write; value, column and row-end flag share one address.
  always_ff @(posedge clk) begin
    if (nzWe_i && (int'(nzWaddr_i) < MAX_NNZ)) begin
      nzVal_q[nzWaddr_i]  <= nzWval_i;
      nzCol_q[nzWaddr_i]  <= nzWcol_i;
      nzLast_q[nzWaddr_i] <= nzWlast_i;
    end
  end

  assign vecRdata_o = vecMem_q[vecRaddr_i];
  assign nzRval_o   = nzVal_q[nzRaddr_i];
  assign nzRcol_o   = nzCol_q[nzRaddr_i];
  assign nzRlast_o  = nzLast_q[nzRaddr_i];

endmodule

// File: rtl/smvm_tx.sv
// ---------------------------------------------------------------------------
// smvm_tx -- streams a sparse matrix / dense vector problem to the SMVM ALU.
//
// On an accepted start the block emits, back to back with out_valid high:
// rows header, cols header, the vector bytes, then one VAL/IDX pair per
// nonzero, padded with zero pairs to a multiple of K. A GAP-cycle quiet
// period with busy still high follows before the next start is accepted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : smvm_tx_if slave (store writes, start/config, stream, status)
// ---------------------------------------------------------------------------
module smvm_tx #(
  parameter int K        = smvm_pkg::K,
  parameter int MAX_COLS = smvm_pkg::MAX_COLS,
  parameter int MAX_NNZ  = smvm_pkg::MAX_NNZ,
  parameter int GAP      = 8
) (
  input  logic      clk,
  input  logic      rst,
  smvm_tx_if.slave  bus
);
  import smvm_pkg::*;

  localparam int PAD_W = (K > 1) ? $clog2(K) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_t              state_q, state_d;
  logic [COLS_W-1:0]   cols_q, cols_d;
  logic [NNZ_W-1:0]    nnz_q, nnz_d;
  logic [PAD_W-1:0]    padNum_q, padNum_d;
  logic [VEC_AW-1:0]   vecCnt_q, vecCnt_d;
  logic [NZ_AW-1:0]    nzCnt_q, nzCnt_d;
  logic [PAD_W-1:0]    padCnt_q, padCnt_d;
  logic [GAP_W-1:0]    gapCnt_q, gapCnt_d;
  logic [HDR_W-1:0]    word_q, word_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                idle;
  logic                cfgOk;
  logic [PAD_W-1:0]    padCalc;
  logic                vecLast;
  logic                nzLastItem;
  logic                padLast;
  logic [VEC_AW-1:0]   vecRaddr;
  logic [NZ_AW-1:0]    nzRaddr;
  logic [VAL_W-1:0]    vecRdata;
  logic [VAL_W-1:0]    nzRval;
  logic [IDX_W-1:0]    nzRcol;
  logic                nzRlast;

  assign idle = (state_q == ST_IDLE);

  // The stores accept writes only while idle, so a running stream never sees
  // its data change; a write in the start cycle lands before any read of it.
  smvm_tx_store #(
    .MAX_COLS (MAX_COLS),
    .MAX_NNZ  (MAX_NNZ)
  ) u_store (
    .clk        (clk),
    .vecWe_i    (bus.vec_we && idle),
    .vecWaddr_i (bus.vec_addr),
    .vecWdata_i (bus.vec_wdata),
    .vecRaddr_i (vecRaddr),
    .vecRdata_o (vecRdata),
    .nzWe_i     (bus.nz_we && idle),
    .nzWaddr_i  (bus.nz_addr),
    .nzWval_i   (bus.nz_val),
    .nzWcol_i   (bus.nz_col),
    .nzWlast_i  (bus.nz_last),
    .nzRaddr_i  (nzRaddr),
    .nzRval_o   (nzRval),
    .nzRcol_o   (nzRcol),
    .nzRlast_o  (nzRlast)
  );

  // Launch checks and the number of pad pairs needed to round the nonzero
  // count up to a multiple of K, both taken from the live cfg inputs.
  always_comb begin
    cfgOk = (bus.cfg_cols != '0) && (int'(bus.cfg_cols) <= MAX_COLS) &&
            (bus.cfg_nnz != '0) && (int'(bus.cfg_nnz) <= MAX_NNZ);
    padCalc = PAD_W'((K - (int'(bus.cfg_nnz) % K)) % K);
  end

  // End-of-phase flags plus the store read addresses. Outputs are registered,
  // so each read fetches the item the *next* word will carry.
  always_comb begin
    vecLast    = ({1'b0, vecCnt_q} == (cols_q - COLS_W'(1)));
    nzLastItem = ({1'b0, nzCnt_q} == (nnz_q - NNZ_W'(1)));
    padLast    = (padCnt_q == (padNum_q - PAD_W'(1)));
    vecRaddr   = (state_q == ST_VEC) ? (vecCnt_q + VEC_AW'(1)) : '0;
    if (state_q == ST_NZI) begin
      nzRaddr = nzCnt_q + NZ_AW'(1);
    end else if (state_q == ST_NZV) begin
      nzRaddr = nzCnt_q;
    end else begin
      nzRaddr = '0;
    end
  end

  // Next-state logic. state_q names the word currently on the outputs; each
  // branch picks the following state and builds the word it will present.
  always_comb begin
    state_d  = state_q;
    cols_d   = cols_q;
    nnz_d    = nnz_q;
    padNum_d = padNum_q;
    vecCnt_d = vecCnt_q;
    nzCnt_d  = nzCnt_q;
    padCnt_d = padCnt_q;
    gapCnt_d = gapCnt_q;
    word_d   = '0;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          if (cfgOk) begin
            state_d  = ST_HROW;
            cols_d   = bus.cfg_cols;
            nnz_d    = bus.cfg_nnz;
            padNum_d = padCalc;
            vecCnt_d = '0;
            nzCnt_d  = '0;
            padCnt_d = '0;
            gapCnt_d = '0;
            busy_d   = 1'b1;
            valid_d  = 1'b1;
            word_d   = hdrWord(bus.cfg_rows);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HROW: begin
        state_d = ST_HCOL;
        valid_d = 1'b1;
        word_d  = hdrWord(cols_q);
      end
      ST_HCOL: begin
        state_d  = ST_VEC;
        vecCnt_d = '0;
        valid_d  = 1'b1;
        word_d   = valWord(vecRdata, 1'b0);
      end
      ST_VEC: begin
        valid_d = 1'b1;
        if (vecLast) begin
          state_d = ST_NZV;
          nzCnt_d = '0;
          word_d  = valWord(nzRval, nzRlast);
        end else begin
          vecCnt_d = vecCnt_q + VEC_AW'(1);
          word_d   = valWord(vecRdata, 1'b0);
        end
      end
      ST_NZV: begin
        state_d = ST_NZI;
        valid_d = 1'b1;
        word_d  = hdrWord({1'b0, nzRcol});
        done_d  = nzLastItem && (padNum_q == '0);
      end
      ST_NZI: begin
        if (nzLastItem) begin
          if (padNum_q != '0) begin
            state_d  = ST_PADV;
            padCnt_d = '0;
            valid_d  = 1'b1;
          end else begin
            state_d  = ST_GAP;
            gapCnt_d = '0;
          end
        end else begin
          state_d = ST_NZV;
          nzCnt_d = nzCnt_q + NZ_AW'(1);
          valid_d = 1'b1;
          word_d  = valWord(nzRval, nzRlast);
        end
      end
      ST_PADV: begin
        state_d = ST_PADI;
        valid_d = 1'b1;
        done_d  = padLast;
      end
      ST_PADI: begin
        if (padLast) begin
          state_d  = ST_GAP;
          gapCnt_d = '0;
        end else begin
          state_d  = ST_PADV;
          padCnt_d = padCnt_q + PAD_W'(1);
          valid_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (gapCnt_q == GAP_W'(GAP - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gapCnt_d = gapCnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and output registers. Reset clears everything except
  // the stores, which cuts any stream short without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cols_q   <= '0;
      nnz_q    <= '0;
      padNum_q <= '0;
      vecCnt_q <= '0;
      nzCnt_q  <= '0;
      padCnt_q <= '0;
      gapCnt_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cols_q   <= cols_d;
      nnz_q    <= nnz_d;
      padNum_q <= padNum_d;
      vecCnt_q <= vecCnt_d;
      nzCnt_q  <= nzCnt_d;
      padCnt_q <= padCnt_d;
      gapCnt_q <= gapCnt_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.val_out   = word_q[HDR_W-1:IPV_W+COL_W];
  assign bus.ipv_out   = word_q[COL_W];
  assign bus.col_out   = word_q[COL_W-1:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
